// File: rtl/hb_interp2.sv
// Halfband x2 interpolator, polyphase, 27-tap prototype.
// Emits centre phase then FIR phase per input sample.
module hb_interp2 #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 38
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_in_valid,
  output logic                     x_in_ready,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_out_valid,
  input  logic                     y_out_ready
);

  localparam int P_W = DATA_W + 1;
  localparam int M_W = 2 * DATA_W + 2;
  localparam int SHR = DATA_W - 2;

  localparam logic signed [DATA_W-1:0] W [7] = '{
    16'sd3, -16'sd25, 16'sd117, -16'sd394,
    16'sd1078, -16'sd2753, 16'sd10165
  };

  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;

  typedef enum logic [2:0] {
    IDLE, PAIR, MULT, ACC, OUT0, OUT1
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] d [14];
  logic signed [P_W-1:0]    p [7];
  logic signed [M_W-1:0]    prod [7];
  logic signed [DATA_W-1:0] centre;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [DATA_W-1:0] y_fir;
  logic                     in_xfer;
  logic                     out_xfer;

  assign x_in_ready = (state == IDLE);
  assign in_xfer    = x_in_valid && x_in_ready;
  assign out_xfer   = y_out_valid && y_out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_xfer) state_nxt = PAIR;
      PAIR:    state_nxt = MULT;
      MULT:    state_nxt = ACC;
      ACC:     state_nxt = OUT0;
      OUT0:    if (out_xfer) state_nxt = OUT1;
      OUT1:    if (out_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < 7; k++)
      acc_sum = acc_sum + ACC_W'(prod[k]);
  end

  // Shift by 14 rather than 15 folds in the x2 zero-stuffing gain
  always_comb begin
    acc_sh = acc >>> SHR;
    y_fir  = acc_sh[DATA_W-1:0];
    if (acc_sh > SAT_HI)
      y_fir = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc_sh < SAT_LO)
      y_fir = {1'b1, {(DATA_W-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 14; i++) d[i] <= '0;
      for (int k = 0; k < 7; k++) begin
        p[k]    <= '0;
        prod[k] <= '0;
      end
      centre      <= '0;
      acc         <= '0;
      y_out       <= '0;
      y_out_valid <= 1'b0;
    end else begin
      if (in_xfer) begin
        d[0] <= x_in;
        for (int i = 1; i < 14; i++) d[i] <= d[i-1];
      end
      if (state == PAIR) begin
        for (int k = 0; k < 7; k++)
          p[k] <= {d[k][DATA_W-1], d[k]}
                + {d[13-k][DATA_W-1], d[13-k]};
        centre <= d[7];
      end
      if (state == MULT) begin
        for (int k = 0; k < 7; k++)
          prod[k] <= M_W'(p[k]) * M_W'(W[k]);
      end
      if (state == ACC) begin
        acc         <= acc_sum;
        y_out       <= centre;
        y_out_valid <= 1'b1;
      end
      if (state == OUT0 && out_xfer) y_out <= y_fir;
      if (state == OUT1 && out_xfer) y_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hb_interp2.sv
// Bench for hb_interp2: table vectors, corner sequences,
// and random input checked against a convolution model.
module tb_hb_interp2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [15:0] x_in;
  logic               x_in_valid;
  logic               x_in_ready;
  logic signed [15:0] y_out;
  logic               y_out_valid;
  logic               y_out_ready;

  int checks   = 0;
  int failures = 0;

  longint hist [14];
  int h [14] = '{3, -25, 117, -394, 1078, -2753, 10165,
                 10165, -2753, 1078, -394, 117, -25, 3};

  typedef struct {
    logic signed [15:0] x;
    int                 c;
    int                 f;
  } vec_t;

  vec_t imp [14];

  always #5 clk = ~clk;

  hb_interp2 #(.DATA_W(16), .ACC_W(38)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x_in        (x_in),
    .x_in_valid  (x_in_valid),
    .x_in_ready  (x_in_ready),
    .y_out       (y_out),
    .y_out_valid (y_out_valid),
    .y_out_ready (y_out_ready)
  );

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // Zero-stuffed odd phase = 14-tap convolution with odd prototype taps
  function automatic void model_push(input longint x,
                                     output longint c,
                                     output longint f);
    longint acc;
    for (int i = 13; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    c = hist[7];
    acc = 0;
    for (int j = 0; j < 14; j++) acc += hist[j] * h[j];
    f = acc >>> 14;
    if (f > 32767) f = 32767;
    if (f < -32768) f = -32768;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    x_in_valid = 1'b0;
    y_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) hist[i] = 0;
    @(negedge clk);
  endtask

  task automatic push(input logic signed [15:0] x, input int stall,
                      input longint ec, input longint ef,
                      input string tag);
    int n;
    logic signed [15:0] held;
    n = 0;
    while (!x_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready"}, x_in_ready, 1);
    x_in = x;
    x_in_valid = 1'b1;
    @(negedge clk);
    x_in_valid = 1'b0;
    n = 0;
    while (!y_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency_in_range"}, (n == 3 || n == 4), 1);
    chk({tag, " centre"}, y_out, ec);
    held = y_out;
    for (int s = 0; s < stall; s++) begin
      x_in = 16'($urandom());
      x_in_valid = s[0];
      @(negedge clk);
      chk({tag, " stall_y"}, y_out, held);
      chk({tag, " stall_valid"}, y_out_valid, 1);
      chk({tag, " stall_in_ready"}, x_in_ready, 0);
    end
    x_in_valid = 1'b0;
    y_out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " fir_valid"}, y_out_valid, 1);
    chk({tag, " fir"}, y_out, ef);
    @(negedge clk);
    y_out_ready = 1'b0;
    chk({tag, " done_valid"}, y_out_valid, 0);
  endtask

  task automatic run_impulse(input string tag);
    longint c, f;
    for (int i = 0; i < 14; i++) begin
      model_push(imp[i].x, c, f);
      push(imp[i].x, 0, imp[i].c, imp[i].f, tag);
    end
  endtask

  task automatic run_signs(input int neg, input string tag);
    int sg [14] = '{1, -1, 1, -1, 1, -1, 1, 1, -1, 1, -1, 1, -1, 1};
    longint c, f, v;
    for (int i = 0; i < 14; i++) begin
      v = (neg != 0) ? -32767 * sg[i] : 32767 * sg[i];
      model_push(v, c, f);
      if (i == 13) f = (neg != 0) ? -32768 : 32767;
      push(16'(v), 0, c, f, tag);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    longint c, f;
    logic signed [15:0] x;
    int n;

    for (int i = 0; i < 14; i++) begin
      imp[i].x = (i == 0) ? 16'sd16384 : 16'sd0;
      imp[i].c = (i == 7) ? 16384 : 0;
    end
    imp[0].f = 3;      imp[1].f = -25;    imp[2].f = 117;
    imp[3].f = -394;   imp[4].f = 1078;   imp[5].f = -2753;
    imp[6].f = 10165;  imp[7].f = 10165;  imp[8].f = -2753;
    imp[9].f = 1078;   imp[10].f = -394;  imp[11].f = 117;
    imp[12].f = -25;   imp[13].f = 3;

    x_in = '0;
    x_in_valid = 1'b0;
    y_out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst y_out", y_out, 0);
    chk("rst y_out_valid", y_out_valid, 0);
    chk("rst x_in_ready", x_in_ready, 1);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) hist[i] = 0;
    repeat (6) @(negedge clk);
    chk("idle no output", y_out_valid, 0);

    run_impulse("impulse");

    do_reset();
    for (int i = 0; i < 20; i++) begin
      model_push(10000, c, f);
      if (i >= 13) begin
        c = 10000;
        f = 9998;
      end
      push(16'sd10000, 0, c, f, "dc");
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      x = 16'($urandom());
      model_push(x, c, f);
      push(x, 5, c, f, "backpressure");
    end

    do_reset();
    run_signs(0, "sat_pos");
    do_reset();
    run_signs(1, "sat_neg");

    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        x = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
      else
        x = 16'($urandom());
      model_push(x, c, f);
      push(x, $urandom_range(0, 3), c, f, "random");
    end

    do_reset();
    x_in = 16'sd1234;
    x_in_valid = 1'b1;
    @(negedge clk);
    x_in_valid = 1'b0;
    n = 0;
    while (!y_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("midop centre valid", y_out_valid, 1);
    y_out_ready = 1'b1;
    @(negedge clk);
    y_out_ready = 1'b0;
    @(negedge clk);
    chk("midop in OUT1", y_out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("midop rst valid", y_out_valid, 0);
    chk("midop rst ready", x_in_ready, 1);
    chk("midop rst y_out", y_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) hist[i] = 0;
    @(negedge clk);
    run_impulse("impulse_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
